inst_rom_loader: RTL and testbench
==================================

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; capacity is 2^ADDR_W 32-bit words.
REQ-002 Parameter BOOT_HOLD, default 1, when 1 keeps cpu_hold_o asserted from reset until the first load completes.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rom_ce_i  input  1  CPU fetch enable.
REQ-006 rom_addr_i  input  32  CPU byte fetch address.
REQ-007 rom_data_o  output  32  instruction word returned to the CPU.
REQ-008 rom_perr_o  output  1  parity error on the current fetch.
REQ-009 ld_start_i  input  1  one-cycle pulse that starts a program load at word 0.
REQ-010 ld_len_i  input  ADDR_W+1  number of words to load, sampled on ld_start_i.
REQ-011 ld_valid_i  input  1  a load byte is present.
REQ-012 ld_data_i  input  8  load byte.
REQ-013 ld_ready_o  output  1  the block accepts a byte this cycle.
REQ-014 ld_count_o  output  ADDR_W+1  number of words committed in the current load.
REQ-015 ld_done_o  output  1  the last load has completed.
REQ-016 cpu_hold_o  output  1  held high to keep the CPU pipeline in reset.

Function
REQ-017 The read path SHALL be combinational: rom_data_o = word[rom_addr_i[ADDR_W+1:2]] when rom_ce_i=1 and cpu_hold_o=0, else 32'h0.
REQ-018 Address bits [1:0] and bits above ADDR_W+1 SHALL be ignored, so fetches wrap modulo capacity.
REQ-019 The FSM SHALL have the states IDLE, LOAD, COMMIT and DONE.
REQ-020 IDLE->LOAD and DONE->LOAD SHALL occur on ld_start_i; this latches len = min(ld_len_i, 2^ADDR_W) and clears the byte index and ld_count_o.
REQ-021 With len=0, ld_start_i SHALL go directly to DONE.
REQ-022 A byte SHALL be accepted when ld_valid_i && ld_ready_o; ld_ready_o=1 only in LOAD.
REQ-023 Bytes SHALL be packed big-endian: the first byte goes to [31:24] and the fourth to [7:0].
REQ-024 On the fourth byte, LOAD->COMMIT; COMMIT writes the word at index ld_count_o and increments ld_count_o, all in one cycle with ld_ready_o=0.
REQ-025 COMMIT->DONE SHALL occur when the new count equals len, else COMMIT->LOAD.
REQ-026 ld_start_i SHALL be ignored in LOAD and COMMIT.
REQ-027 ld_valid_i SHALL be ignored outside LOAD.
REQ-028 ld_done_o=1 only in DONE.
REQ-029 cpu_hold_o=1 in LOAD and COMMIT, and also in IDLE when BOOT_HOLD=1; 0 otherwise.
REQ-030 A read of a word during the cycle it is being committed is blocked by cpu_hold_o, so no read/write collision is visible.

Reset
REQ-031 While rst=0: FSM=IDLE; byte index, len and ld_count_o = 0; ld_ready_o=0; ld_done_o=0; cpu_hold_o=BOOT_HOLD; rom_data_o=0.
REQ-032 The storage array SHALL NOT be reset; a reset mid-load abandons the partial word, and already-committed words are kept.

Configuration
REQ-033 The macro INST_ROM_PARITY_EN SHALL control word parity.
REQ-034 With INST_ROM_PARITY_EN defined, each word stores an even-parity bit computed in COMMIT, and rom_perr_o = 1 when rom_ce_i=1, cpu_hold_o=0 and the stored parity mismatches the word read.
REQ-035 Without INST_ROM_PARITY_EN, no parity storage exists and rom_perr_o is tied 0; the port list is unchanged.

Structure
REQ-036 The shared defines file SHALL hold InstAddrBus, InstDataBus, the InstMemNumLog2 default and the four FSM state encodings.
REQ-037 One sub-module, inst_rom_mem, SHALL hold the storage array (with the optional parity bit), with one synchronous write port and one combinational read port.

Verification
REQ-038 Reset then idle, BOOT_HOLD=1 -> cpu_hold_o=1, rom_data_o=0 for rom_ce_i=1 at any address.
REQ-039 Start with len=2; bytes 12 34 56 78 9A BC DE F0 sent with continuous valid -> ld_ready_o low exactly one cycle after bytes 4 and 8; ld_done_o=1; fetches at 0x0 and 0x4 return 0x12345678 and 0x9ABCDEF0; cpu_hold_o=0.
REQ-040 Len=0 start -> DONE next cycle, ld_count_o=0, memory unchanged.
REQ-041 Fetch at 0x00001004 with ADDR_W=10 -> same data as 0x4 (wrap); rom_ce_i=0 -> 0x0.
REQ-042 Reset asserted after 6 bytes of a len=2 load -> word 0 retained, IDLE, ld_count_o=0; a new len=1 load overwrites word 0 correctly.
REQ-043 With INST_ROM_PARITY_EN, force a stored data bit flip via the bench -> rom_perr_o=1 on fetch of that word only.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared bus widths, default memory depth and loader FSM encodings.
package inst_rom_loader_pkg;

    localparam int InstAddrBus    = 32;
    localparam int InstDataBus    = 32;
    localparam int InstMemNumLog2 = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction storage: one synchronous write port, one combinational read port.
// INST_ROM_PARITY_EN adds an even-parity bit per word and a read-side check.
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = InstMemNumLog2
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [InstDataBus-1:0] wdata_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [InstDataBus-1:0] rdata_o,
    output logic                   rperr_o
);

    logic [InstDataBus-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

`ifdef INST_ROM_PARITY_EN
    logic par_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) par_q[waddr_i] <= ^wdata_i;
    end

    assign rperr_o = (^rdata_o) != par_q[raddr_i];
`else
    assign rperr_o = 1'b0;
`endif

endmodule

// File: rtl/inst_rom_loader.sv
// Byte-stream program loader feeding a word-addressed instruction ROM.
// Optional word parity controlled by INST_ROM_PARITY_EN (see inst_rom_mem).
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W    = InstMemNumLog2,
    parameter int BOOT_HOLD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [InstDataBus-1:0] rom_data_o,
    output logic                   rom_perr_o,
    input  logic                   ld_start_i,
    input  logic [ADDR_W:0]        ld_len_i,
    input  logic                   ld_valid_i,
    input  logic [7:0]             ld_data_i,
    output logic                   ld_ready_o,
    output logic [ADDR_W:0]        ld_count_o,
    output logic                   ld_done_o,
    output logic                   cpu_hold_o
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic HOLD_RST = (BOOT_HOLD != 0);

    ld_state_e              state_q, state_d;
    logic [ADDR_W:0]        len_q, len_d, count_q, count_d, len_clamp;
    logic [1:0]             idx_q, idx_d;
    logic [InstDataBus-1:0] word_q, word_d;
    logic                   ready_q, done_q, hold_q;
    logic                   mem_we, mem_perr;
    logic [InstDataBus-1:0] mem_rdata;

    assign len_clamp = (ld_len_i > CAP) ? CAP : ld_len_i;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        word_d  = word_q;
        count_d = count_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ld_start_i) begin
                    len_d   = len_clamp;
                    idx_d   = 2'd0;
                    count_d = '0;
                    state_d = (len_clamp == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid_i && ready_q) begin
                    // Shift left so the first byte ends up in [31:24].
                    word_d = {word_q[23:0], ld_data_i};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                mem_we  = 1'b1;
                count_d = count_q + 1'b1;
                state_d = (count_d == len_q) ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= 2'd0;
            word_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= HOLD_RST;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            count_q <= count_d;
            ready_q <= (state_d == ST_LOAD);
            done_q  <= (state_d == ST_DONE);
            hold_q  <= (state_d == ST_LOAD) || (state_d == ST_COMMIT) ||
                       ((state_d == ST_IDLE) && HOLD_RST);
        end
    end

    inst_rom_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (count_q[ADDR_W-1:0]),
        .wdata_i (word_q),
        .raddr_i (rom_addr_i[ADDR_W+1:2]),
        .rdata_o (mem_rdata),
        .rperr_o (mem_perr)
    );

    // Hold covers the commit cycle, so a same-cycle read of the written word never leaks.
    assign rom_data_o = (rom_ce_i && !hold_q) ? mem_rdata : '0;
    assign rom_perr_o = rom_ce_i && !hold_q && mem_perr;

    logic unused_addr;
    assign unused_addr = ^{rom_addr_i[InstAddrBus-1:ADDR_W+2], rom_addr_i[1:0]};

    assign ld_ready_o = ready_q;
    assign ld_done_o  = done_q;
    assign ld_count_o = count_q;
    assign cpu_hold_o = hold_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed self-checking bench for inst_rom_loader (ADDR_W=10, BOOT_HOLD=1).
module tb_inst_rom_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rom_ce_i;
    logic [31:0]   rom_addr_i;
    logic [31:0]   rom_data_o;
    logic          rom_perr_o;
    logic          ld_start_i;
    logic [AW:0]   ld_len_i;
    logic          ld_valid_i;
    logic [7:0]    ld_data_i;
    logic          ld_ready_o;
    logic [AW:0]   ld_count_o;
    logic          ld_done_o;
    logic          cpu_hold_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_W(AW), .BOOT_HOLD(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .rom_perr_o (rom_perr_o),
        .ld_start_i (ld_start_i),
        .ld_len_i   (ld_len_i),
        .ld_valid_i (ld_valid_i),
        .ld_data_i  (ld_data_i),
        .ld_ready_o (ld_ready_o),
        .ld_count_o (ld_count_o),
        .ld_done_o  (ld_done_o),
        .cpu_hold_o (cpu_hold_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic ce,
                         input logic [31:0] exp);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
        chk(tag, rom_data_o, exp);
    endtask

    task automatic start(input logic [AW:0] len);
        ld_len_i   = len;
        ld_start_i = 1'b1;
        @(posedge clk); #1;
        ld_start_i = 1'b0;
    endtask

    // Presents one byte with valid held high; counts cycles spent waiting for ready.
    task automatic send_byte(input logic [7:0] b, inout int stalls);
        logic r;
        int   guard;
        ld_valid_i = 1'b1;
        ld_data_i  = b;
        guard      = 0;
        r          = 1'b0;
        while (!r && guard < 20) begin
            @(negedge clk);
            r = ld_ready_o;
            if (!r) stalls++;
            @(posedge clk); #1;
            guard++;
        end
        if (!r) chk("ready_timeout", 32'(r), 32'd1);
        ld_valid_i = 1'b0;
    endtask

    initial begin
        int   stalls;
        logic [7:0] seq8 [8];
        seq8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        rst = 1'b0; rom_ce_i = 1'b1; rom_addr_i = '0; ld_start_i = 1'b0;
        ld_len_i = '0; ld_valid_i = 1'b0; ld_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold",  32'(cpu_hold_o), 32'd1);
        chk("rst_ready", 32'(ld_ready_o), 32'd0);
        chk("rst_done",  32'(ld_done_o),  32'd0);
        chk("rst_count", 32'(ld_count_o), 32'd0);
        fetch("rst_data", 32'h0000_0008, 1'b1, 32'h0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", 32'(cpu_hold_o), 32'd1);
        fetch("idle_data0", 32'h0, 1'b1, 32'h0);
        fetch("idle_data1", 32'h0000_0ffc, 1'b1, 32'h0);

        // Two-word load, continuous valid.
        start(11'd2);
        chk("load_ready", 32'(ld_ready_o), 32'd1);
        chk("load_hold",  32'(cpu_hold_o), 32'd1);
        stalls = 0;
        for (int i = 0; i < 8; i++) send_byte(seq8[i], stalls);
        chk("stalls_mid", 32'(stalls), 32'd1);
        @(negedge clk);
        chk("commit_ready", 32'(ld_ready_o), 32'd0);
        chk("commit_done",  32'(ld_done_o),  32'd0);
        @(posedge clk); #1;
        chk("done_flag",  32'(ld_done_o),  32'd1);
        chk("done_count", 32'(ld_count_o), 32'd2);
        chk("done_hold",  32'(cpu_hold_o), 32'd0);
        chk("done_ready", 32'(ld_ready_o), 32'd0);
        fetch("rd_w0", 32'h0, 1'b1, 32'h1234_5678);
        fetch("rd_w1", 32'h4, 1'b1, 32'h9ABC_DEF0);
        fetch("rd_w1_lowbits", 32'h7, 1'b1, 32'h9ABC_DEF0);
        chk("perr_clean", 32'(rom_perr_o), 32'd0);

        // Address wrap and chip-enable gating.
        fetch("rd_wrap", 32'h0000_1004, 1'b1, 32'h9ABC_DEF0);
        fetch("rd_ce0",  32'h0000_0004, 1'b0, 32'h0);

        // Zero-length load goes straight to DONE.
        start(11'd0);
        chk("len0_done",  32'(ld_done_o),  32'd1);
        chk("len0_count", 32'(ld_count_o), 32'd0);
        chk("len0_hold",  32'(cpu_hold_o), 32'd0);
        fetch("len0_w0", 32'h0, 1'b1, 32'h1234_5678);

        // Reset after six bytes of a two-word load.
        start(11'd2);
        stalls = 0;
        send_byte(8'h11, stalls); send_byte(8'h22, stalls);
        send_byte(8'h33, stalls); send_byte(8'h44, stalls);
        send_byte(8'h55, stalls); send_byte(8'h66, stalls);
        chk("pre_rst_count", 32'(ld_count_o), 32'd1);
        rst = 1'b0;
        #2;
        chk("mid_rst_count", 32'(ld_count_o), 32'd0);
        chk("mid_rst_ready", 32'(ld_ready_o), 32'd0);
        chk("mid_rst_hold",  32'(cpu_hold_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(ld_done_o), 32'd0);
        fetch("post_rst_blk", 32'h0, 1'b1, 32'h0);
        start(11'd0);
        fetch("keep_w0", 32'h0, 1'b1, 32'h1122_3344);
        fetch("keep_w1", 32'h4, 1'b1, 32'h9ABC_DEF0);

        // One-word reload; a start pulse while loading must be ignored.
        start(11'd1);
        start(11'd0);
        chk("start_ign_ready", 32'(ld_ready_o), 32'd1);
        chk("start_ign_done",  32'(ld_done_o),  32'd0);
        stalls = 0;
        send_byte(8'hA1, stalls); send_byte(8'hB2, stalls);
        send_byte(8'hC3, stalls); send_byte(8'hD4, stalls);
        @(posedge clk); #1;
        chk("len1_done",  32'(ld_done_o),  32'd1);
        chk("len1_count", 32'(ld_count_o), 32'd1);
        fetch("len1_w0", 32'h0, 1'b1, 32'hA1B2_C3D4);
        fetch("len1_w1", 32'h4, 1'b1, 32'h9ABC_DEF0);

`ifdef INST_ROM_PARITY_EN
        dut.u_mem.mem_q[1] = 32'h9ABC_DEF1;
        #1;
        fetch("par_w1_data", 32'h4, 1'b1, 32'h9ABC_DEF1);
        chk("par_w1_err", 32'(rom_perr_o), 32'd1);
        fetch("par_w0_data", 32'h0, 1'b1, 32'hA1B2_C3D4);
        chk("par_w0_ok", 32'(rom_perr_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
